// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory slave front end.
package spi_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serial-out register for the read response.
// done rises with the last shifted bit and stays set until the next load/clear.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    assign serial_out = sreg[DATA_W-1];
    assign busy       = (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            sreg <= data;
            cnt  <= CNT_W'(DATA_W);
            done <= 1'b0;
        end else if (shift && busy) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: MOSI frames -> rx_data/rx_valid, tx_data -> MISO on read-data.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse for aborted frames and select-bit mismatches.
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    state_t             state;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-2:0] shift_in;
    logic               rx_done;
    logic               rd_addr_seen;
    logic               sel_ok;

    logic tx_active, tx_load, tx_shift, tx_clear;
    logic tx_bit, tx_busy, tx_done;

`ifdef SPI_FRAME_ERR_EN
    logic sel;
    // shift_in MSB holds payload bit 9 on the edge that samples bit 0.
    assign sel_ok = (sel == shift_in[FRAME_W-2]);
`else
    assign sel_ok = 1'b1;
`endif

    assign tx_active = (state == READ_DATA) && rx_done && !SS_n;
    assign tx_load   = tx_active && tx_valid && !tx_busy && !tx_done;
    assign tx_shift  = tx_active && tx_busy;
    assign tx_clear  = (state != IDLE) && SS_n;

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (tx_load),
        .shift      (tx_shift),
        .clear      (tx_clear),
        .data       (tx_data),
        .serial_out (tx_bit),
        .busy       (tx_busy),
        .done       (tx_done)
    );

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_in     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            sel          <= 1'b0;
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (tx_clear) begin
                // Abort: drop any partial frame but keep rd_addr_seen.
`ifdef SPI_FRAME_ERR_EN
                if (bit_cnt != '0)
                    frame_err <= 1'b1;
`endif
                state    <= IDLE;
                bit_cnt  <= '0;
                shift_in <= '0;
                rx_done  <= 1'b0;
                MISO     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n)
                            state <= CHK_CMD;
                    end
                    CHK_CMD: begin
`ifdef SPI_FRAME_ERR_EN
                        sel <= MOSI;
`endif
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!rx_done) begin
                            shift_in <= {shift_in[FRAME_W-3:0], MOSI};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt  <= '0;
                                shift_in <= '0;
                                rx_done  <= 1'b1;
                                if (sel_ok) begin
                                    rx_data  <= {shift_in, MOSI};
                                    rx_valid <= 1'b1;
                                    if (state == READ_ADD)
                                        rd_addr_seen <= 1'b1;
                                end
`ifdef SPI_FRAME_ERR_EN
                                else begin
                                    frame_err <= 1'b1;
                                end
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (state == READ_DATA) begin
                            MISO <= tx_busy ? tx_bit : 1'b0;
                            if (tx_done)
                                rd_addr_seen <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave with rx-word and MISO-bit scoreboards.
// Build with +define+SPI_FRAME_ERR_EN to also exercise frame_err.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    logic [9:0] exp_rx[$];
    logic       exp_miso[$];

    spi_slave dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rx_valid pulses; reads the pre-edge value at each rising edge.
    always @(posedge clk) begin
        if (rx_valid === 1'b1)
            pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Edge 0 samples SS_n=0, edge 1 samples the select bit.
    task automatic start_frame(input logic sel, input state_t exp_st);
        SS_n = 1'b0;
        tick();
        MOSI = sel;
        tick();
        check("state_after_sel", 32'(dut.state), 32'(exp_st));
    endtask

    task automatic send_bits(input logic [9:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            MOSI = frame[9 - i];
            tick();
        end
    endtask

    task automatic pop_rx();
        logic [9:0] e;
        e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 10'h3FF;
        check("rx_valid_pulse", 32'(rx_valid), 32'd1);
        check("rx_data", 32'(rx_data), 32'(e));
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        check("state_idle_after_ss", 32'(dut.state), 32'(IDLE));
    endtask

    task automatic push_miso(input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            exp_miso.push_back(d[i]);
    endtask

    // Called at the negedge after edge 11; RAM answers during the next cycle.
    task automatic ram_answer(input logic [7:0] d);
        tick();
        tx_data  = d;
        tx_valid = 1'b1;
        push_miso(d);
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic check_miso_bits(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("miso_bit", 32'(MISO), 32'(exp_miso.pop_front()));
        end
    endtask

    initial begin
        int pc;
        rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        check("reset_frame_err", 32'(frame_err), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Write address 0x0A5
        pc = pulse_cnt;
        start_frame(1'b0, WRITE);
        exp_rx.push_back(10'h0A5);
        send_bits(10'h0A5, 10);
        pop_rx();
        tick();
        check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
        check("wr_addr_pulse_count", 32'(pulse_cnt), 32'(pc + 1));
        check("write_holds", 32'(dut.state), 32'(WRITE));
        end_frame();

        // Write data 0x13C, with a stray tx_valid that must be ignored
        start_frame(1'b0, WRITE);
        exp_rx.push_back({CMD_WR_DATA, 8'h3C});
        send_bits({CMD_WR_DATA, 8'h3C}, 10);
        pop_rx();
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        tick();
        tick();
        check("stray_tx_miso", 32'(MISO), 32'd0);
        check("write_data_holds", 32'(dut.state), 32'(WRITE));
        check("rx_data_holds", 32'(rx_data), 32'h13C);
        end_frame();

        // Read address, then full read-data response 0xC3
        start_frame(1'b1, READ_ADD);
        exp_rx.push_back(10'h207);
        send_bits(10'h207, 10);
        pop_rx();
        tick();
        check("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'd1);
        end_frame();

        start_frame(1'b1, READ_DATA);
        exp_rx.push_back(10'h3A5);
        send_bits(10'h3A5, 10);
        pop_rx();
        ram_answer(8'hC3);
        check("miso_idle_before_msb", 32'(MISO), 32'd0);
        check_miso_bits(8);
        tick();
        check("miso_zero_after_read", 32'(MISO), 32'd0);
        check("rd_addr_seen_cleared", 32'(dut.rd_addr_seen), 32'd0);
        tick();
        check("miso_hold_zero", 32'(MISO), 32'd0);
        end_frame();

        // Read address again, then abort the response mid-shift
        start_frame(1'b1, READ_ADD);
        exp_rx.push_back(10'h212);
        send_bits(10'h212, 10);
        pop_rx();
        end_frame();
        start_frame(1'b1, READ_DATA);
        exp_rx.push_back(10'h3FF);
        send_bits(10'h3FF, 10);
        pop_rx();
        ram_answer(8'h5A);
        check_miso_bits(3);
        exp_miso.delete();
        end_frame();
        check("abort_read_miso", 32'(MISO), 32'd0);
        check("abort_read_seen_kept", 32'(dut.rd_addr_seen), 32'd1);

        // rd_addr_seen preserved -> READ_DATA; async reset mid-shift
        start_frame(1'b1, READ_DATA);
        exp_rx.push_back(10'h300);
        send_bits(10'h300, 10);
        pop_rx();
        ram_answer(8'h96);
        check_miso_bits(2);
        exp_miso.delete();
        #2 rst = 1'b1;
        #1;
        check("async_rst_miso", 32'(MISO), 32'd0);
        check("async_rst_rx_data", 32'(rx_data), 32'd0);
        check("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        check("async_rst_seen", 32'(dut.rd_addr_seen), 32'd0);
        tick();
        rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        tick();
        start_frame(1'b1, READ_ADD);
        exp_rx.push_back(10'h2C3);
        send_bits(10'h2C3, 10);
        pop_rx();
        end_frame();

        // Abort after 5 payload bits
        pc = pulse_cnt;
        start_frame(1'b0, WRITE);
        send_bits(10'h0F0, 5);
        SS_n = 1'b1;
        tick();
        check("abort_state_idle", 32'(dut.state), 32'(IDLE));
`ifdef SPI_FRAME_ERR_EN
        check("abort_frame_err", 32'(frame_err), 32'd1);
`endif
        tick();
`ifdef SPI_FRAME_ERR_EN
        check("abort_frame_err_pulse", 32'(frame_err), 32'd0);
`endif
        check("abort_no_rx_valid", 32'(pulse_cnt), 32'(pc));
        check("abort_rx_data_kept", 32'(rx_data), 32'h2C3);

`ifdef SPI_FRAME_ERR_EN
        // Select 0 with payload bit 9 set
        pc = pulse_cnt;
        start_frame(1'b0, WRITE);
        send_bits(10'h301, 10);
        check("mismatch_frame_err", 32'(frame_err), 32'd1);
        check("mismatch_no_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        check("mismatch_frame_err_pulse", 32'(frame_err), 32'd0);
        check("mismatch_pulse_count", 32'(pulse_cnt), 32'(pc));
        check("mismatch_rx_data_kept", 32'(rx_data), 32'h2C3);
        end_frame();
`endif

        check("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
